// File: rtl/dual_pt_sram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external registered-read dual-port SRAM.
// Optional synchronous flush port clr is enabled by defining FIFO_CLEAR_EN.
module dual_pt_sram_fifo_ctrl #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef FIFO_CLEAR_EN
  input  logic          clr,
`endif
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW:0]   count,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addrw,
  output logic [DW-1:0] mem_din,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addrr,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   mem_cnt, next_count;
  logic          rd_pend, skid_valid;
  logic [DW-1:0] skid_data;
  logic          push, pop, fetch, flush;
  logic [1:0]    ob, ob_after;

`ifdef FIFO_CLEAR_EN
  assign flush = clr;
`else
  assign flush = 1'b0;
`endif

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  // Words already committed to the output side: held, parked in skid, or arriving from the SRAM.
  assign ob       = 2'(m_valid) + 2'(skid_valid) + 2'(rd_pend);
  assign ob_after = ob - 2'(pop);
  assign fetch    = (mem_cnt != '0) && (ob_after < 2'd2);

  assign next_count = count + (AW+1)'(push) - (AW+1)'(pop);

  assign mem_wen   = push;
  assign mem_addrw = wptr;
  assign mem_din   = s_data;
  assign mem_ren   = fetch;
  assign mem_addrr = rptr;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_cnt    <= '0;
      count      <= '0;
      rd_pend    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      s_ready    <= 1'b0;
    end else if (flush) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_cnt    <= '0;
      count      <= '0;
      rd_pend    <= 1'b0;
      skid_valid <= 1'b0;
      m_valid    <= 1'b0;
      s_ready    <= 1'b1;
    end else begin
      if (push)  wptr <= wptr + 1'b1;
      if (fetch) rptr <= rptr + 1'b1;
      mem_cnt <= mem_cnt + (AW+1)'(push) - (AW+1)'(fetch);
      count   <= next_count;
      s_ready <= next_count < DEPTH_C;
      rd_pend <= fetch;

      if (pop) begin
        if (skid_valid) begin
          // Skid word advances; a word landing this edge takes its place in skid.
          m_data <= skid_data;
          if (rd_pend) skid_data  <= mem_dout;
          else         skid_valid <= 1'b0;
        end else if (rd_pend) begin
          m_data <= mem_dout;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (rd_pend) begin
        if (!m_valid) begin
          m_data  <= mem_dout;
          m_valid <= 1'b1;
        end else begin
          skid_data  <= mem_dout;
          skid_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_pt_sram_fifo_ctrl.sv
// Self-checking bench for dual_pt_sram_fifo_ctrl with a behavioural SRAM and a queue reference model.
module tb_dual_pt_sram_fifo_ctrl;
  localparam int DW = 8, AW = 4, DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic          s_ready, m_valid, mem_wen, mem_ren;
  logic [DW-1:0] m_data, mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addrw, mem_addrr;
  logic [DW-1:0] sram [DEPTH];

  int total = 0;
  int bad = 0;
  logic [DW-1:0] q[$];
  bit live = 0;

  dual_pt_sram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FIFO_CLEAR_EN
    .clr(clr),
`endif
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
    .mem_wen(mem_wen), .mem_addrw(mem_addrw), .mem_din(mem_din),
    .mem_ren(mem_ren), .mem_addrr(mem_addrr), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Registered-read SRAM; output holds while ren is low.
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addrw] <= mem_din;
    if (mem_ren) mem_dout <= sram[mem_addrr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // Scoreboard step: compare against the queue model, record handshakes, advance one cycle.
  task automatic tick();
    #1;
    total++;
    if (count !== 5'(q.size())) begin
      bad++; $display("FAIL count: got %0d want %0d", count, q.size());
    end
    if (live) begin
      total++;
      if (s_ready !== 1'(q.size() < DEPTH)) begin
        bad++; $display("FAIL s_ready: got %0b want %0b", s_ready, q.size() < DEPTH);
      end
    end
    if (m_valid && m_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++; $display("FAIL pop_empty: got data %h with model empty", m_data);
      end else begin
        if (m_data !== q[0]) begin
          bad++; $display("FAIL pop_data: got %h want %h", m_data, q[0]);
        end
        void'(q.pop_front());
      end
    end
    if (s_valid && s_ready) q.push_back(s_data);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    live = 0; s_valid = 0; m_ready = 0; clr = 0;
    rst_n = 0;
    q.delete();
    #7;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    #1;
    live = 1;
  endtask

  task automatic drain();
    s_valid = 0;
    m_ready = 1;
    for (int n = 0; n < 64 && (q.size() != 0 || m_valid); n++) tick();
    m_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    m_ready = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = 8'(8'h50 + i);
      tick();
    end
    s_valid = 0;
    tick();
    total++;
    if (count !== 5'd5) begin bad++; $display("FAIL pre_reset_count: got %0d want 5", count); end
    s_valid = 1;
    live = 0;
    rst_n = 0;
    q.delete();
    #1;
    total++;
    if ({m_valid, s_ready, mem_wen, mem_ren} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got m_valid/s_ready/wen/ren=%b want 0000",
                      {m_valid, s_ready, mem_wen, mem_ren});
    end
    total++;
    if (count !== 5'd0 || m_data !== 8'h00) begin
      bad++; $display("FAIL reset_data: got count=%0d m_data=%h want 0/00", count, m_data);
    end
    @(posedge clk); #1;
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_hold: got s_ready=%b want 0", s_ready); end
    @(negedge clk);
    rst_n = 1;
    #1;
    total++;
    if (s_ready !== 1'b0) begin bad++; $display("FAIL release_ready: got %b want 0", s_ready); end
    @(posedge clk); #1;
    s_valid = 0;
    total++;
    if (s_ready !== 1'b1 || count !== 5'd0) begin
      bad++; $display("FAIL post_release: got s_ready=%b count=%0d want 1/0", s_ready, count);
    end
    live = 1;
    @(negedge clk); #1;
  endtask

  task automatic test_single();
    s_valid = 1; s_data = 8'hA5; m_ready = 1;
    #1;
    total++;
    if (mem_wen !== 1'b1 || mem_addrw !== 4'd0 || mem_din !== 8'hA5) begin
      bad++; $display("FAIL single_write: got wen=%b addrw=%0d din=%h want 1/0/a5", mem_wen, mem_addrw, mem_din);
    end
    tick();
    s_valid = 0;
    #1;
    total++;
    if (mem_ren !== 1'b1 || mem_addrr !== 4'd0) begin
      bad++; $display("FAIL single_fetch: got ren=%b addrr=%0d want 1/0", mem_ren, mem_addrr);
    end
    tick();
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL single_early: got m_valid=%b want 0", m_valid); end
    tick();
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      bad++; $display("FAIL single_out: got m_valid=%b m_data=%h want 1/a5", m_valid, m_data);
    end
    tick();
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL single_after: got m_valid=%b want 0", m_valid); end
    m_ready = 0;
  endtask

  task automatic test_fill();
    do_reset();
    m_ready = 0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1; s_data = 8'(i);
      tick();
    end
    total++;
    if (s_ready !== 1'b0 || count !== 5'd16) begin
      bad++; $display("FAIL full: got s_ready=%b count=%0d want 0/16", s_ready, count);
    end
    s_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (mem_wen !== 1'b0) begin bad++; $display("FAIL full_write: got wen=%b want 0", mem_wen); end
      tick();
    end
    s_valid = 0;
  endtask

  task automatic test_drain();
    m_ready = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      total++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        bad++; $display("FAIL drain_seq: got m_valid=%b m_data=%h want 1/%h", m_valid, m_data, 8'(i));
      end
      tick();
    end
    total++;
    if (m_valid !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL drain_end: got m_valid=%b count=%0d want 0/0", m_valid, count);
    end
    m_ready = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      s_valid = 1; s_data = 8'(8'h20 + i);
      tick();
    end
    drain();
    for (int i = 0; i < 10; i++) begin
      s_valid = 1; s_data = 8'(8'h30 + i);
      #1;
      total++;
      if (mem_wen !== 1'b1 || mem_addrw !== 4'((10 + i) % 16)) begin
        bad++; $display("FAIL wrap_addr: got wen=%b addrw=%0d want 1/%0d", mem_wen, mem_addrw, (10 + i) % 16);
      end
      tick();
    end
    drain();
    total++;
    if (q.size() != 0 || m_valid !== 1'b0) begin
      bad++; $display("FAIL wrap_drain: got %0d left m_valid=%b want 0/0", q.size(), m_valid);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    do_reset();
    for (int c = 0; c < 20000 && pushed < 1000; c++) begin
      s_valid = 1'($urandom % 2);
      s_data  = 8'($urandom);
      m_ready = 1'($urandom % 2);
      if (s_valid && s_ready) pushed++;
      tick();
    end
    total++;
    if (pushed != 1000) begin bad++; $display("FAIL random_budget: got %0d pushes want 1000", pushed); end
    drain();
    total++;
    if (q.size() != 0 || m_valid !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL random_drain: got left=%0d m_valid=%b count=%0d want 0/0/0", q.size(), m_valid, count);
    end
  endtask

`ifdef FIFO_CLEAR_EN
  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = 8'(8'h60 + i);
      tick();
    end
    s_data = 8'h77; clr = 1;
    #1;
    total++;
    if (mem_wen !== 1'b1) begin bad++; $display("FAIL clr_wen: got %b want 1", mem_wen); end
    @(posedge clk); #1;
    clr = 0; s_valid = 0;
    q.delete();
    total++;
    if (count !== 5'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++; $display("FAIL clr_state: got count=%0d m_valid=%b s_ready=%b want 0/0/1", count, m_valid, s_ready);
    end
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_wrap();
    test_random();
`ifdef FIFO_CLEAR_EN
    test_clear();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
